if_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It owns the fetch PC, issues word reads to instruction memory over a valid/ready handshake and delivers instructions into the IF/ID pipeline register. It sits directly upstream of the decode-stage branch unit and consumes that unit's next-PC result through the redirect port. MIPS branch-delay-slot semantics are enforced here.

---
 rtl/if_stage.sv | 112 +++++++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads over a valid/ready
// handshake and fills the IF/ID register, keeping MIPS branch-delay-slot order.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    logic [31:0] pc;          // next address to issue
    logic [31:0] req_pc;      // address of the outstanding / buffered fetch
    logic [31:0] rbuf;
    logic [31:0] pend_pc;
    logic        outst;
    logic        rbuf_valid;
    logic        pend;

    logic        rbuf_valid_nxt;
    logic        redirect_take;
    logic        slot_issued;
    logic        accept;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        rbuf_valid_nxt = stall && (rbuf_valid || imem_rsp_valid);
        redirect_take  = redirect_valid && id_valid && !stall;
        slot_issued    = (pc == id_pc + 32'd8);
        // When the delay slot is already in flight, the sequential successor sitting
        // in pc must never be requested: hold the request for the redirect cycle.
        imem_req_valid = !rst && (!outst || imem_rsp_valid) && !rbuf_valid_nxt
                         && !(redirect_take && slot_issued);
        accept         = imem_req_valid && imem_req_ready;
    end

    assign imem_req_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            outst      <= 1'b0;
            rbuf_valid <= 1'b0;
            pend       <= 1'b0;
            id_valid   <= 1'b0;
            id_pc      <= 32'd0;
            id_instr   <= 32'd0;
        end else begin
            rbuf_valid <= rbuf_valid_nxt;

            if (accept) begin
                outst <= 1'b1;
                if (pend) begin
                    pc   <= pend_pc;
                    pend <= 1'b0;
                end else if (redirect_take && !slot_issued) begin
                    // Delay slot accepted in the same cycle the branch resolves.
                    pc <= redirect_pc;
                end else begin
                    pc <= pc + 32'd4;
                end
            end else begin
                if (imem_rsp_valid) begin
                    outst <= 1'b0;
                end
                if (redirect_take && slot_issued) begin
                    pc <= redirect_pc;
                end else if (redirect_take) begin
                    pend <= 1'b1;
                end
            end

            if (!stall) begin
                if (rbuf_valid) begin
                    id_valid <= 1'b1;
                    id_pc    <= req_pc;
                    id_instr <= rbuf;
                end else if (imem_rsp_valid) begin
                    id_valid <= 1'b1;
                    id_pc    <= req_pc;
                    id_instr <= imem_rsp_data;
                end else begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload registers carry no reset; the flags above gate every use of them.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc <= pc;
        end
        if (stall && imem_rsp_valid) begin
            rbuf <= imem_rsp_data;
        end
        if (redirect_take && !slot_issued && !accept) begin
            pend_pc <= redirect_pc;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a memory model and decode-stage driver feed the stage while a
// scoreboard checks the IF/ID stream against a program-order reference model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic        st;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        ov;
        logic [31:0] opc;
        logic        ea;
        logic        rq;
        logic [31:0] eaddr;
    } dir_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int delivered = 0;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    // Program-order reference: next address the decode stage should see, and
    // whether the instruction awaiting consumption is a delay slot.
    logic [31:0] m_next;
    logic        cur_is_slot;

    logic        obs_valid;
    logic [31:0] obs_pc;
    logic        obs_req_valid;
    logic [31:0] obs_req_addr;
    logic        acc;

    dir_t dir [21];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // One clock cycle, entered and left at a falling edge: acts as decode stage and memory.
    task automatic cycle(input logic st, input logic rdy, input int lat,
                         input logic br, input logic [31:0] tgt, input logic junk);
        logic consume;
        logic branching;
        obs_valid      = id_valid;
        obs_pc         = id_pc;
        stall          = st;
        consume        = (id_valid === 1'b1) && !st;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (consume) begin
            branching = br && !cur_is_slot;
            exp_q.push_back('{m_next, instr_of(m_next)});
            cur_is_slot = branching;
            if (branching) begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                m_next         = tgt;
            end else begin
                m_next = m_next + 32'd4;
            end
        end else if (junk) begin
            redirect_valid = 1'b1;
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = rdy;
        #1;
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        acc           = imem_req_valid && imem_req_ready;
        if (obs_req_valid) begin
            check("req_addr_align", 32'(obs_req_addr[1:0]), 32'd0);
        end
        if (acc) begin
            check("mem_one_outstanding", 32'(mem_q.size()), 32'd0);
            mem_q.push_back('{obs_req_addr, cyc + lat});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        exp_q.delete();
        mem_q.delete();
        repeat (n) begin
            @(negedge clk);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_id_valid", 32'(id_valid), 32'd0);
            check("rst_id_pc", id_pc, 32'd0);
            check("rst_id_instr", id_instr, 32'd0);
        end
        rst = 1'b0;
        exp_q.push_back('{RESET_PC, instr_of(RESET_PC)});
        m_next      = RESET_PC + 32'd4;
        cur_is_slot = 1'b0;
    endtask

    task automatic run_dir(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cycle(dir[i].st, dir[i].rdy, 1, dir[i].br, dir[i].tgt, 1'b0);
            check($sformatf("dir%0d_id_valid", i), 32'(obs_valid), 32'(dir[i].ov));
            if (dir[i].ov) check($sformatf("dir%0d_id_pc", i), obs_pc, dir[i].opc);
            check($sformatf("dir%0d_accept", i), 32'(acc), 32'(dir[i].ea));
            if (dir[i].rq) check($sformatf("dir%0d_req_valid", i), 32'(obs_req_valid), 32'd1);
            if (dir[i].ea || dir[i].rq) check($sformatf("dir%0d_req_addr", i), obs_req_addr, dir[i].eaddr);
        end
    endtask

    // Scoreboard monitor: every newly loaded valid IF/ID entry must match the model.
    initial begin
        logic loaded;
        exp_t e;
        forever begin
            @(posedge clk);
            loaded = !rst && !stall;
            #1;
            if (loaded && id_valid === 1'b1) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL id_unexpected: got pc %h expected no instruction", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_instr", id_instr, e.instr);
                end
            end
        end
    end

    initial begin
        int d0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        m_next         = RESET_PC;
        cur_is_slot    = 1'b0;

        //          st    rdy   br    tgt           ov    opc           ea    rq    eaddr
        dir[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h3000};
        dir[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h3004};
        dir[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3000,     1'b1, 1'b0, 32'h3008};
        dir[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b0, 1'b0, 32'h0};
        dir[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b0, 1'b0, 32'h0};
        dir[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b0, 1'b0, 32'h0};
        dir[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b1, 1'b0, 32'h300C};
        dir[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3008,     1'b1, 1'b0, 32'h3010};
        dir[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300C,     1'b1, 1'b0, 32'h3014};
        dir[9]  = '{1'b0, 1'b1, 1'b1, 32'h3400,     1'b1, 32'h3010,     1'b0, 1'b0, 32'h0};
        dir[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3014,     1'b1, 1'b0, 32'h3400};
        dir[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h3404};
        dir[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3400,     1'b1, 1'b0, 32'h3408};
        dir[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3404,     1'b1, 1'b0, 32'h340C};
        dir[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3408,     1'b1, 1'b0, 32'h3410};
        dir[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h340C,     1'b0, 1'b1, 32'h3414};
        dir[16] = '{1'b0, 1'b0, 1'b1, 32'h3800,     1'b1, 32'h3410,     1'b0, 1'b1, 32'h3414};
        dir[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h3414};
        dir[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h3800};
        dir[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3414,     1'b1, 1'b0, 32'h3804};
        dir[20] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3800,     1'b1, 1'b0, 32'h3808};

        @(negedge clk);
        do_reset(3);
        run_dir(0, 20);

        d0 = delivered;
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(1, 3),
                  $urandom_range(0, 6) == 0, 32'h3000 + ($urandom_range(0, 1023) << 2),
                  $urandom_range(0, 9) == 0);
        end
        check("random_progress", 32'(delivered - d0 >= 300), 32'd1);

        // Fill the response buffer under stall, then reset mid-stream.
        for (int n = 0; n < 3; n++) cycle(1'b1, 1'b1, 1, 1'b0, 32'd0, 1'b0);
        do_reset(2);
        run_dir(0, 2);

        d0 = delivered;
        for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 8, $urandom_range(1, 2),
                  $urandom_range(0, 4) == 0, 32'h3000 + ($urandom_range(0, 1023) << 2),
                  $urandom_range(0, 9) == 0);
        end
        for (int n = 0; n < 20; n++) cycle(1'b0, 1'b1, 1, 1'b0, 32'd0, 1'b0);
        check("tail_progress", 32'(delivered - d0 >= 60), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
